// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage sequencer.
// Walks stage -> butterfly -> phase counters for one in-place transform and
// derives the operand and twiddle addresses combinationally from them.
module fft_stage_sequencer #(
  parameter  int N_POINTS  = 8,
  parameter  int PHASES    = 3,
  parameter  int VLD_PHASE = 2,
  localparam int LN        = $clog2(N_POINTS),
  localparam int PW        = (PHASES > 2) ? $clog2(PHASES) : 1,
  localparam int SW        = (LN > 2) ? $clog2(LN) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  output logic          busy,
  output logic [PW-1:0] phase,
  output logic [SW-1:0] stage,
  output logic [LN-2:0] bfly,
  output logic [LN-1:0] addr_a,
  output logic [LN-1:0] addr_b,
  output logic [LN-2:0] tw_addr,
  output logic          vld,
  output logic          last,
  output logic          done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [PW-1:0] PH_MAX = PW'(PHASES - 1);
  localparam logic [PW-1:0] PH_VLD = PW'(VLD_PHASE);
  localparam logic [LN-2:0] BF_MAX = '1;  // N_POINTS/2-1 is all ones
  localparam logic [SW-1:0] ST_MAX = SW'(LN - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [LN-2:0] bfly_q,  bfly_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          done_q,  done_d;

  // Next-state logic: nested phase/butterfly/stage counters with abort priority.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    bfly_d  = bfly_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Counters are already zero here, so entering RUN starts at 0/0/0.
        if (start && !abort) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          bfly_d  = '0;
          stage_d = '0;
        end else if (!stall) begin
          if (phase_q != PH_MAX) begin
            phase_d = phase_q + PW'(1);
          end else begin
            phase_d = '0;
            if (bfly_q != BF_MAX) begin
              bfly_d = bfly_q + (LN-1)'(1);
            end else begin
              bfly_d = '0;
              if (stage_q != ST_MAX) begin
                stage_d = stage_q + SW'(1);
              end else begin
                stage_d = '0;
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state_q <= IDLE;
      phase_q <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bfly_q  <= bfly_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  logic [LN-2:0] off_mask;
  logic [LN-2:0] off;
  logic [LN-2:0] grp;
  logic [LN-1:0] half_span;

  // Zero-latency addressing: span h=2^stage, group and offset from bfly.
  always_comb begin
    off_mask  = ~({(LN-1){1'b1}} << stage_q);
    off       = bfly_q & off_mask;
    grp       = bfly_q >> stage_q;
    half_span = LN'(1) << stage_q;
    addr_a    = ({grp, 1'b0} << stage_q) | {1'b0, off};
    addr_b    = addr_a + half_span;
    tw_addr   = off << (ST_MAX - stage_q);
  end

  assign busy  = (state_q == RUN);
  assign phase = phase_q;
  assign stage = stage_q;
  assign bfly  = bfly_q;
  assign vld   = busy & ~stall & (phase_q == PH_VLD);
  assign last  = vld & (bfly_q == BF_MAX);
  assign done  = done_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (default parameters).
// The reference model tracks only "running" and a linear RUN-cycle index k;
// all expected counters and addresses are derived from k with arithmetic.
module tb_fft_stage_sequencer;

  localparam int N_POINTS  = 8;
  localparam int PHASES    = 3;
  localparam int VLD_PHASE = 2;
  localparam int LN        = 3;
  localparam int HALF      = N_POINTS / 2;
  localparam int TOTAL     = LN * HALF * PHASES;  // 36
  localparam int PW        = 2;
  localparam int SW        = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, stall, abort;
  logic          busy;
  logic [PW-1:0] phase;
  logic [SW-1:0] stage;
  logic [LN-2:0] bfly;
  logic [LN-1:0] addr_a, addr_b;
  logic [LN-2:0] tw_addr;
  logic          vld, last, done;

  fft_stage_sequencer #(
    .N_POINTS (N_POINTS),
    .PHASES   (PHASES),
    .VLD_PHASE(VLD_PHASE)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .stall  (stall),
    .abort  (abort),
    .busy   (busy),
    .phase  (phase),
    .stage  (stage),
    .bfly   (bfly),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw_addr(tw_addr),
    .vld    (vld),
    .last   (last),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_run  = 1'b0;
  int m_k    = 0;
  bit m_done = 1'b0;

  // Per-scenario observation counters
  int cyc, busy_cnt, vld_cnt, done_cnt, done_at, last_mask;

  function automatic int m_phase();
    return m_run ? m_k % PHASES : 0;
  endfunction
  function automatic int m_bfly();
    return m_run ? (m_k / PHASES) % HALF : 0;
  endfunction
  function automatic int m_stage();
    return m_run ? m_k / (PHASES * HALF) : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit st);
    int ph, bf, sg, h, grp, off, a, ev, el;
    ph  = m_phase();
    bf  = m_bfly();
    sg  = m_stage();
    h   = 1 << sg;
    grp = bf / h;
    off = bf % h;
    a   = grp * 2 * h + off;
    ev  = (m_run && !st && ph == VLD_PHASE) ? 1 : 0;
    el  = (ev == 1 && bf == HALF - 1) ? 1 : 0;
    check("busy",    32'(busy),    32'(m_run));
    check("phase",   32'(phase),   ph);
    check("stage",   32'(stage),   sg);
    check("bfly",    32'(bfly),    bf);
    check("addr_a",  32'(addr_a),  a);
    check("addr_b",  32'(addr_b),  a + h);
    check("tw_addr", 32'(tw_addr), off * (1 << (LN - 1 - sg)));
    check("vld",     32'(vld),     ev);
    check("last",    32'(last),    el);
    check("done",    32'(done),    32'(m_done));
  endtask

  task automatic model_step(input bit s, input bit st, input bit ab);
    m_done = 1'b0;
    if (m_run) begin
      if (ab) begin
        m_run = 1'b0;
        m_k   = 0;
      end else if (!st) begin
        m_k++;
        if (m_k == TOTAL) begin
          m_run  = 1'b0;
          m_k    = 0;
          m_done = 1'b1;
        end
      end
    end else if (s && !ab) begin
      m_run = 1'b1;
      m_k   = 0;
    end
  endtask

  task automatic clear_stats();
    cyc = 0; busy_cnt = 0; vld_cnt = 0; done_cnt = 0; done_at = -1; last_mask = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit s, input bit st, input bit ab);
    start = s; stall = st; abort = ab;
    #1;
    check_outputs(st);
    if (m_run && m_stage() == 1 && m_bfly() == 3) begin
      check("s1b3_addr_a", 32'(addr_a), 5);
      check("s1b3_addr_b", 32'(addr_b), 7);
      check("s1b3_tw",     32'(tw_addr), 2);
    end
    if (m_run && m_stage() == 2 && m_bfly() == 1) begin
      check("s2b1_addr_a", 32'(addr_a), 1);
      check("s2b1_addr_b", 32'(addr_b), 5);
      check("s2b1_tw",     32'(tw_addr), 1);
    end
    if (busy) busy_cnt++;
    if (vld) begin
      vld_cnt++;
      if (last) last_mask |= (1 << vld_cnt);
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
    cyc++;
    @(posedge clk);
    model_step(s, st, ab);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rstn = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;

    // Reset state, before any clock edge
    #2;
    check_outputs(1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Plain run: first start after reset release accepted on the first edge
    clear_stats();
    step(1, 0, 0);
    for (int i = 0; i < 38; i++) step(0, 0, 0);
    check("run_busy_cycles", busy_cnt, TOTAL);
    check("run_vld_pulses",  vld_cnt,  12);
    check("run_last_pos",    last_mask, (1 << 4) | (1 << 8) | (1 << 12));
    check("run_done_count",  done_cnt, 1);
    check("run_done_cycle",  done_at,  37);

    // Stall for 5 cycles at stage 1, bfly 2, phase 1
    clear_stats();
    step(1, 0, 0);
    guard = 0;
    while (!(m_run && m_stage() == 1 && m_bfly() == 2 && m_phase() == 1) && guard < 100) begin
      step(0, 0, 0);
      guard++;
    end
    check("stall_point_reached", 32'(guard < 100), 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    check("stall_busy_cycles", busy_cnt, TOTAL + 5);
    check("stall_done_count",  done_cnt, 1);

    // Abort at stage 2, bfly 0, then a clean run
    clear_stats();
    step(1, 0, 0);
    guard = 0;
    while (!(m_run && m_stage() == 2 && m_bfly() == 0) && guard < 100) begin
      step(0, 0, 0);
      guard++;
    end
    check("abort_point_reached", 32'(guard < 100), 1);
    step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check("abort_no_done", done_cnt, 0);
    step(1, 0, 1);  // abort overrides start in IDLE
    check("abort_blocks_start", 32'(busy), 0);
    clear_stats();
    step(1, 0, 0);
    for (int i = 0; i < 38; i++) step(0, 0, 0);
    check("post_abort_busy", busy_cnt, TOTAL);
    check("post_abort_done", done_cnt, 1);

    // Start held high: runs chain with busy low only in each done cycle
    clear_stats();
    for (int i = 0; i < 1 + 3 * (TOTAL + 1); i++) step(1, 0, 0);
    check("chain_done_count", done_cnt, 3);
    check("chain_last_done",  done_at,  3 * (TOTAL + 1));
    check("chain_busy",       busy_cnt, 3 * TOTAL);
    for (int i = 0; i < 40; i++) step(0, 0, 0);

    // Asynchronous reset mid-run, between edges, low for 0.3 clock
    clear_stats();
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    #1 rstn = 1'b0;
    m_run = 1'b0; m_k = 0; m_done = 1'b0;
    #1 check_outputs(1'b0);
    #2 rstn = 1'b1;
    @(negedge clk);
    clear_stats();
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    check("rst_no_done", done_cnt, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
